w_grf_writer: RTL
=================

# w_grf_writer

Write-back (W) stage of the five-stage MIPS pipeline and the driver of the general register file's single write port. It captures the M-stage result bundle on each clock, extends load data by width and signedness, selects the write-back value (ALU, memory, or link address), and presents address, data, enable and PC to the register file one cycle later. It also counts retired register writes for the testbench and flags misaligned loads.

## Interface
- `WIDTH`, 32: datapath width; only 32 is supported.
- `PC_RESET`, 32'h0000_3000: reset value of `grf_pc`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; state clears immediately while low.
- `flush` in 1: replaces the M bundle being captured with a bubble (valid = 0).
- `valid_M` in 1: the M bundle holds a real instruction.
- `pc_M` in 32: PC of the M instruction.
- `ir_M` in 32: instruction word; passed through unchanged to `ir_W`.
- `rd_M` in 5: destination register; 0 means no write.
- `wd_sel_M` in 2: 0 = ALU, 1 = memory, 2 = PC+8, 3 = reserved (treated as no write).
- `ld_type_M` in 3: 0 = LW, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU; other values are treated as LW.
- `alu_M` in 32: ALU result; its low two bits are the byte offset for loads.
- `dm_rdata_M` in 32: raw aligned word from data memory.
- `grf_we` out 1: register-file write enable (Addr3 port enable).
- `grf_addr` out 5: register-file write address.
- `grf_wd` out 32: register-file write data.
- `grf_pc` out 32: PC of the instruction performing the write, used for the commit log.
- `ir_W` out 32: registered instruction word.
- `misalign` out 1: the captured load was misaligned; its write is suppressed.
- `retire_cnt` out 32: number of register writes committed since reset.

## Operation
- W register: on each rising edge it captures `{valid_M & ~flush, pc_M, ir_M, rd_M, wd_sel_M, ld_type_M, alu_M, dm_rdata_M}`.
- Load extension uses offset `off` = `alu[1:0]`:
  - LB / LBU select byte `off`, sign-extended or zero-extended.
  - LH / LHU select halfword `off[1]`, sign-extended or zero-extended.
  - LW passes the whole word.
- Misalignment is a halfword load with `off[0]`=1, or LW with `off` != 0. It is qualified by valid and by `wd_sel`=1.
- Write data: `grf_wd` = ALU, extended load, or `pc+8`, chosen by `wd_sel`.
- Write enable: `grf_we` = valid & (rd != 0) & (`wd_sel` != 3) & ~misalign.
  - When `grf_we`=0, `grf_addr` is still driven with the captured rd, and `grf_wd` still shows the selected value.
- `grf_pc` and `ir_W` always reflect the captured bundle, bubbles included. A bubble carries pc = 0 and ir = 0.
- `retire_cnt` increments by 1 on every rising edge where `grf_we`=1. It wraps from 0xFFFF_FFFF to 0.
- The block performs no internal write-to-read bypass; the register file handles same-cycle read-after-write itself.

## Timing
- Latency: M inputs at edge N produce the write-port outputs after edge N. The register file commits at edge N+1.
- Outputs are combinational from the W register only, never from M inputs.
- While `reset`=0, and after its release:
  - all W registers clear: valid = 0, rd = 0, ir = 0, data = 0;
  - `grf_pc` = `PC_RESET`;
  - `retire_cnt` = 0;
  - therefore `grf_we` = 0, `grf_addr` = 0, `grf_wd` = 0, `misalign` = 0.
- Reset asserted mid-write: outputs drop to reset values immediately (asynchronously), and no increment occurs at the following edge.
- First edge after reset deassertion: normal capture.
- `flush` together with `valid_M`=1: flush wins. The captured bundle is a bubble, `grf_we` = 0 the next cycle, and the counter is unchanged.
- Back-to-back writes to the same rd: each cycle presents its own write. The later one overwrites at the following edge.
- A counter increment and its corresponding `grf_we` are in the same cycle. The count is visible one edge later.

## Test plan
- Reset: hold `reset`=0 with `valid_M`=1 and `rd_M`=5 -> `grf_we`=0, `grf_pc`=0x3000 and `retire_cnt`=0 throughout. Release -> the first capture appears after the next edge.
- ALU write: pc 0x3004, rd 8, `wd_sel` 0, alu 0x1234_5678 -> next cycle `grf_we`=1, `grf_addr`=8, `grf_wd`=0x1234_5678, `grf_pc`=0x3004, `retire_cnt`=1 after the following edge.
- Loads with `dm_rdata`=0x80FF_7F01:
  - LB, off 3 -> 0xFFFF_FF80.
  - LBU, off 3 -> 0x0000_0080.
  - LH, off 2 -> 0xFFFF_80FF.
  - LHU, off 0 -> 0x0000_7F01.
  - LW, off 0 -> 0x80FF_7F01.
- Link and suppression: `wd_sel` 2 with pc 0x3010 -> `grf_wd`=0x3018. rd 0 -> `grf_we`=0 and the counter is unchanged.
- Misalign: LH with alu 0x0000_1001 -> `misalign`=1 and `grf_we`=0. LW with alu 0x2 -> `misalign`=1.
- Flush and async reset:
  - `flush`=1 with a valid write -> `grf_we`=0 and pc 0 next cycle.
  - Drop `reset` between edges while `grf_we`=1 -> outputs clear before the next edge, and the count is not incremented.

Source files
------------

// File: rtl/w_grf_writer_if.sv
// M-stage result bundle into the W stage and register-file write port out of it.
interface w_grf_writer_if;
    logic        flush;
    logic        valid_M;
    logic [31:0] pc_M;
    logic [31:0] ir_M;
    logic [4:0]  rd_M;
    logic [1:0]  wd_sel_M;
    logic [2:0]  ld_type_M;
    logic [31:0] alu_M;
    logic [31:0] dm_rdata_M;

    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [31:0] ir_W;
    logic        misalign;
    logic [31:0] retire_cnt;

    // Pipeline/bench side: drives the M bundle, observes the write port.
    modport master (
        output flush, valid_M, pc_M, ir_M, rd_M, wd_sel_M, ld_type_M, alu_M, dm_rdata_M,
        input  grf_we, grf_addr, grf_wd, grf_pc, ir_W, misalign, retire_cnt
    );

    // W stage side.
    modport slave (
        input  flush, valid_M, pc_M, ir_M, rd_M, wd_sel_M, ld_type_M, alu_M, dm_rdata_M,
        output grf_we, grf_addr, grf_wd, grf_pc, ir_W, misalign, retire_cnt
    );
endinterface

// File: rtl/w_grf_writer.sv
// W stage: registers the M bundle, extends load data, drives the GRF write port.
module w_grf_writer #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input logic          clk,
    input logic          reset,
    w_grf_writer_if.slave bus
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] ir;
        logic [4:0]       rd;
        logic [1:0]       wd_sel;
        logic [2:0]       ld_type;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] rdata;
    } w_bundle_t;

    localparam w_bundle_t W_RESET = '{pc: PC_RESET, default: '0};

    w_bundle_t        r_w;
    w_bundle_t        w_next;
    logic [WIDTH-1:0] r_retire_cnt;

    logic [1:0]       w_off;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_wd;
    logic             w_misalign;
    logic             w_we;

    // Next W contents: a flushed slot becomes an all-zero bubble.
    always_comb begin
        w_next = '{
            valid:   bus.valid_M,
            pc:      bus.pc_M,
            ir:      bus.ir_M,
            rd:      bus.rd_M,
            wd_sel:  bus.wd_sel_M,
            ld_type: bus.ld_type_M,
            alu:     bus.alu_M,
            rdata:   bus.dm_rdata_M
        };
        if (bus.flush) begin
            w_next = '0;
        end
    end

    // W pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w <= W_RESET;
        end else begin
            r_w <= w_next;
        end
    end

    // Load extension by width/signedness; unknown load types behave as LW.
    always_comb begin
        w_off  = r_w.alu[1:0];
        w_byte = r_w.rdata[{w_off, 3'b000} +: 8];
        w_half = r_w.rdata[{w_off[1], 4'b0000} +: 16];
        w_load = r_w.rdata;
        case (r_w.ld_type)
            LD_LB:   w_load = {{(WIDTH-8){w_byte[7]}}, w_byte};
            LD_LBU:  w_load = {{(WIDTH-8){1'b0}}, w_byte};
            LD_LH:   w_load = {{(WIDTH-16){w_half[15]}}, w_half};
            LD_LHU:  w_load = {{(WIDTH-16){1'b0}}, w_half};
            default: w_load = r_w.rdata;
        endcase
    end

    // Misaligned load detection, only for real memory write-backs.
    always_comb begin
        w_misalign = 1'b0;
        if (r_w.valid && (r_w.wd_sel == SEL_MEM)) begin
            case (r_w.ld_type)
                LD_LB, LD_LBU: w_misalign = 1'b0;
                LD_LH, LD_LHU: w_misalign = w_off[0];
                default:       w_misalign = (w_off != 2'b00);
            endcase
        end
    end

    // Write-back value select and write enable.
    always_comb begin
        w_wd = r_w.alu;
        case (r_w.wd_sel)
            SEL_ALU:  w_wd = r_w.alu;
            SEL_MEM:  w_wd = w_load;
            SEL_LINK: w_wd = r_w.pc + WIDTH'(8);
            default:  w_wd = r_w.alu;
        endcase
        w_we = r_w.valid && (r_w.rd != 5'd0) && (r_w.wd_sel != SEL_NONE) && !w_misalign;
    end

    // Retired-write counter, bumped in the cycle its write is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_we) begin
            r_retire_cnt <= r_retire_cnt + WIDTH'(1);
        end
    end

    assign bus.grf_we     = w_we;
    assign bus.grf_addr   = r_w.rd;
    assign bus.grf_wd     = w_wd;
    assign bus.grf_pc     = r_w.pc;
    assign bus.ir_W       = r_w.ir;
    assign bus.misalign   = w_misalign;
    assign bus.retire_cnt = r_retire_cnt;

endmodule
